pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges the load-use/branch stall request from the hazard detection logic, taken-branch flushes from ID, and occupancy of the iterative multiply/divide unit into one set of pipeline write enables. A small FSM tracks the multi-cycle mult/div operation and stalls only instructions that depend on HI/LO or need the unit. It sits between the hazard detection unit and the PC / IF-ID / ID-EX control registers.

## Interface
- MULDIV_CYCLES, 4: cycles the iterative mult/div unit occupies after issue; legal range 1..2^CNT_W.
- CNT_W, 3: width of the internal cycle counter.

- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- HazardStall  in  1  stall request from hazard detection (1 = hold IF/ID, bubble ID/EX).
- BranchTaken  in  1  branch/jump resolved taken in ID this cycle.
- MulDivStart  in  1  mult/div instruction in EX this cycle (issue).
- IFIDUsesHiLo  in  1  instruction in ID reads HI/LO (mfhi/mflo) or is mult/div.
- PCWrite  out  1  PC load enable.
- IFIDWrite  out  1  IF/ID register load enable.
- ControlWrite  out  1  0 = zero control fields into ID/EX (bubble).
- IFIDFlush  out  1  clear IF/ID next edge.
- MulDivBusy  out  1  mult/div unit occupied.
- HiLoWrite  out  1  one-cycle strobe: commit mult/div result to HI/LO.

## Operation
- States: IDLE, RUN, DONE. Internal down-counter Cnt[CNT_W-1:0].
- IDLE: MulDivStart=1 -> RUN, Cnt <= MULDIV_CYCLES-1. Else stay.
- RUN: Cnt==0 -> DONE, else Cnt <= Cnt-1. MulDivStart ignored.
- DONE: HiLoWrite=1 for exactly this cycle. MulDivStart=1 -> RUN with counter reload (back-to-back issue), else -> IDLE.
- MulDivBusy = 1 in RUN and DONE.
- Stall = HazardStall | (MulDivBusy & IFIDUsesHiLo). DONE still stalls dependents; the HI/LO write lands at the end of DONE, so the dependent reads the new value the following cycle.
- Stall=1: PCWrite=IFIDWrite=ControlWrite=0, IFIDFlush=0.
- Stall=0: PCWrite=IFIDWrite=ControlWrite=1, IFIDFlush=BranchTaken.
- Priority: stall over flush. A taken branch during a stall is not flushed; ID re-resolves it on the cycle the stall releases.
- Independent instructions (IFIDUsesHiLo=0) flow freely in RUN, including taken-branch flushes.

## Timing
- State and Cnt are registered. All outputs are combinational from state and the current inputs, with zero-cycle latency to the pipeline registers.
- Issue at edge N (MulDivStart high before N) -> MulDivBusy high from N for MULDIV_CYCLES+1 cycles; HiLoWrite high in the last of them.
- MULDIV_CYCLES=1: RUN lasts one cycle, then DONE.
- While Reset=0: state=IDLE, Cnt=0. Outputs are forced to PCWrite=IFIDWrite=ControlWrite=0, IFIDFlush=0, MulDivBusy=0, HiLoWrite=0.
- Reset asserted mid-RUN aborts the operation; no HiLoWrite is issued. First cycle after release is IDLE.
- HazardStall and MulDivStart in the same IDLE cycle: issue accepted (EX holds the mult/div) and the stall is applied.

## Configuration
- STALL_COUNT_EN defined: adds output StallCount[15:0].
  - Increments on each cycle with Stall=1, saturating at 16'hFFFF.
  - Cleared by Reset.
- STALL_COUNT_EN undefined: no port, no counter logic.

## Structure
- Shared package holds:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default MULDIV_CYCLES.
- No sub-module. The stall counter stays an inline conditional block.

## Test plan
- Reset held low, inputs random -> all enables 0, MulDivBusy=0; on release with inputs 0 -> PCWrite=IFIDWrite=ControlWrite=1.
- MulDivStart for 1 cycle, MULDIV_CYCLES=4, IFIDUsesHiLo=0 -> MulDivBusy high 5 cycles, HiLoWrite high only on the 5th, PCWrite stays 1.
- Same issue with IFIDUsesHiLo=1 throughout -> PCWrite=0 for 5 cycles, then 1 on the 6th cycle with MulDivBusy=0.
- HazardStall=1 and BranchTaken=1 together -> IFIDFlush=0, enables 0; next cycle HazardStall=0, BranchTaken=1 -> IFIDFlush=1, PCWrite=1.
- MulDivStart reasserted in DONE -> Cnt reloads to 3, no IDLE gap, second HiLoWrite 5 cycles after the first.
- Reset pulsed low at cycle 2 of RUN -> HiLoWrite never asserted; with STALL_COUNT_EN, StallCount returns to 0.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller_pkg
//
// Shared definitions for the pipeline stall/flush sequencer.
//   - State encoding of the mult/div tracking FSM (IDLE, RUN, DONE). These are
//     plain 2-bit constants so legacy code that compares raw state values
//     keeps working.
//   - Default occupancy of the iterative mult/div unit and the default width
//     of the down-counter that times it.
// -----------------------------------------------------------------------------
package pipeline_stall_controller_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;  // unit free
  localparam logic [1:0] RUN  = 2'd1;  // iterating, counter running down
  localparam logic [1:0] DONE = 2'd2;  // last busy cycle, HI/LO commit strobe

  // Cycles the mult/div unit stays occupied after issue (legal 1..2**CNT_W)
  localparam int DEFAULT_MULDIV_CYCLES = 4;

  // Width of the internal cycle counter
  localparam int DEFAULT_CNT_W = 3;

endpackage : pipeline_stall_controller_pkg

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges the
// hazard-detection stall request, taken-branch flushes resolved in ID and the
// occupancy of the iterative mult/div unit into one set of pipeline write
// enables for the PC, IF/ID and ID/EX control registers.
//
// A small FSM (IDLE -> RUN -> DONE) follows the multi-cycle mult/div
// operation. Only instructions that read HI/LO or need the unit are stalled
// while it is busy; independent instructions (and their branch flushes) keep
// flowing.
//
// Parameters
//   MULDIV_CYCLES  cycles the unit is occupied after issue (1..2**CNT_W)
//   CNT_W          width of the internal down-counter
//
// Ports
//   Clk           in   pipeline clock, rising edge
//   Reset         in   asynchronous, active-low reset
//   HazardStall   in   stall request from hazard detection
//   BranchTaken   in   branch/jump resolved taken in ID this cycle
//   MulDivStart   in   mult/div instruction in EX this cycle (issue)
//   IFIDUsesHiLo  in   instruction in ID reads HI/LO or is mult/div
//   PCWrite       out  PC load enable
//   IFIDWrite     out  IF/ID register load enable
//   ControlWrite  out  0 = bubble (zero control fields into ID/EX)
//   IFIDFlush     out  clear IF/ID on the next edge
//   MulDivBusy    out  mult/div unit occupied (RUN or DONE)
//   HiLoWrite     out  one-cycle strobe committing the result to HI/LO
//   StallCount    out  [15:0] saturating count of stalled cycles
//                      (present only when STALL_COUNT_EN is defined)
//
// Build option
//   STALL_COUNT_EN  adds the StallCount port and its counter.
// -----------------------------------------------------------------------------
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MULDIV_CYCLES = DEFAULT_MULDIV_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        HazardStall,
  input  logic        BranchTaken,
  input  logic        MulDivStart,
  input  logic        IFIDUsesHiLo,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        ControlWrite,
  output logic        IFIDFlush,
  output logic        MulDivBusy,
  output logic        HiLoWrite
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0] StallCount
`endif
);

  // Counter load value on issue: RUN lasts MULDIV_CYCLES cycles (Cnt counts
  // RELOAD..0), followed by one DONE cycle.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MULDIV_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic busy;
  logic stall;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (MulDivStart) begin
          state_next = RUN;
          cnt_next   = RELOAD;
        end
      end
      RUN: begin
        // A new issue cannot reach EX while the unit iterates, so MulDivStart
        // is ignored here.
        if (cnt == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE: begin
        // Back-to-back issue: reload straight from DONE with no IDLE gap.
        if (MulDivStart) begin
          state_next = RUN;
          cnt_next   = RELOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline controls (combinational, zero-cycle latency)
  // ---------------------------------------------------------------------------
  // DONE still counts as busy: HI/LO is written at the end of DONE, so a
  // dependent mfhi/mflo may only leave ID on the following cycle.
  assign busy  = (state == RUN) || (state == DONE);
  assign stall = HazardStall | (busy & IFIDUsesHiLo);

  // Everything is forced inactive while Reset is low. Stall wins over flush:
  // a taken branch held in ID during a stall is re-resolved when it releases.
  assign PCWrite      = Reset & ~stall;
  assign IFIDWrite    = Reset & ~stall;
  assign ControlWrite = Reset & ~stall;
  assign IFIDFlush    = Reset & ~stall & BranchTaken;
  assign MulDivBusy   = Reset & busy;
  assign HiLoWrite    = Reset & (state == DONE);

`ifdef STALL_COUNT_EN
  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      StallCount <= '0;
    end else if (stall && (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end
`endif

endmodule : pipeline_stall_controller
